// File: rtl/cpu_v2.sv
// Multi-cycle CPU: 16-bit encoded three-operand ISA over one synchronous-read memory,
// with direct/indirect operands, ready/valid input, strobed output and a halt state.
module cpu_v2 #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int PC_START   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] mem_in,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] sp,
    output logic                  halted
);

    typedef enum logic [3:0] {
        S_FETCH, S_FETCH_IMM, S_DECODE, S_RD_B, S_RD_C,
        S_RD_A, S_PTR_A, S_IN_WAIT, S_EXEC, S_HALT
    } state_t;

    localparam logic [3:0] OP_MOV  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_DIV  = 4'h4;
    localparam logic [3:0] OP_IN   = 4'h7;
    localparam logic [3:0] OP_OUT  = 4'h8;
    localparam logic [3:0] OP_STOP = 4'hF;

    state_t                state_q, state_d;
    logic [1:0]            phase_q, phase_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]           ir_q, ir_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] c_q, c_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] dest_q, dest_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  out_valid_q, out_valid_d;

    logic [3:0]            opcode;
    logic                  a_ind, b_ind, c_ind, is_imm;
    logic [ADDR_WIDTH-1:0] a_reg, b_reg, c_reg;
    logic                  opnd_ind;
    logic [ADDR_WIDTH-1:0] opnd_reg;
    logic                  opnd_done;
    state_t                after_opnd;
    logic [DATA_WIDTH-1:0] result;

    assign opcode = ir_q[15:12];
    assign a_ind  = ir_q[11];
    assign b_ind  = ir_q[7];
    assign c_ind  = ir_q[3];
    assign a_reg  = ADDR_WIDTH'(ir_q[10:8]);
    assign b_reg  = ADDR_WIDTH'(ir_q[6:4]);
    assign c_reg  = ADDR_WIDTH'(ir_q[2:0]);
    assign is_imm = (opcode == OP_MOV) && (ir_q[3:0] == 4'b1000);

    // Once the sources are in hand, an indirect destination still needs its pointer.
    assign after_opnd = a_ind ? S_PTR_A : ((opcode == OP_IN) ? S_IN_WAIT : S_EXEC);

    always_comb begin
        opnd_ind = a_ind;
        opnd_reg = a_reg;
        case (state_q)
            S_RD_B:  begin opnd_ind = b_ind; opnd_reg = b_reg; end
            S_RD_C:  begin opnd_ind = c_ind; opnd_reg = c_reg; end
            default: ;
        endcase
    end

    // Indirect reads spend phases 0/1 on the pointer and 2/3 on the data.
    assign opnd_done = (phase_q == (opnd_ind ? 2'd3 : 2'd1));

    always_comb begin
        case (opcode)
            OP_ADD:  result = b_q + c_q;
            OP_SUB:  result = b_q - c_q;
            OP_MUL:  result = b_q * c_q;
            OP_DIV:  result = (c_q == '0) ? '1 : (b_q / c_q);
            default: result = b_q;
        endcase
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        b_d         = b_q;
        c_d         = c_q;
        ptr_d       = ptr_q;
        dest_d      = dest_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = pc_q;
        mem_data    = result;

        case (state_q)
            S_FETCH, S_FETCH_IMM: begin
                if (phase_q[0]) begin
                    pc_d = pc_q + ADDR_WIDTH'(1);
                    if (state_q == S_FETCH) begin
                        ir_d    = mem_in[15:0];
                        state_d = ((mem_in[15:12] == OP_MOV) && (mem_in[3:0] == 4'b1000))
                                  ? S_FETCH_IMM : S_DECODE;
                    end else begin
                        b_d     = mem_in;   // immediate travels through the B operand register
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                dest_d = a_reg;
                case (opcode)
                    OP_MOV:                         state_d = is_imm ? after_opnd : S_RD_B;
                    OP_ADD, OP_SUB, OP_MUL, OP_DIV: state_d = S_RD_B;
                    OP_IN:                          state_d = after_opnd;
                    OP_OUT:                         state_d = S_RD_A;
                    OP_STOP:                        state_d = S_HALT;
                    default:                        state_d = S_FETCH;
                endcase
            end
            S_RD_B, S_RD_C, S_RD_A: begin
                mem_addr = phase_q[1] ? ptr_q : opnd_reg;
                if (opnd_ind && (phase_q == 2'd1))
                    ptr_d = mem_in[ADDR_WIDTH-1:0];
                if (opnd_done) begin
                    case (state_q)
                        S_RD_B: begin
                            b_d     = mem_in;
                            state_d = (opcode == OP_MOV) ? after_opnd : S_RD_C;
                        end
                        S_RD_C: begin
                            c_d     = mem_in;
                            state_d = after_opnd;
                        end
                        default: begin
                            out_d       = mem_in;
                            out_valid_d = 1'b1;
                            state_d     = S_FETCH;
                        end
                    endcase
                end
            end
            S_PTR_A: begin
                mem_addr = a_reg;
                if (phase_q[0]) begin
                    dest_d  = mem_in[ADDR_WIDTH-1:0];
                    state_d = (opcode == OP_IN) ? S_IN_WAIT : S_EXEC;
                end
            end
            S_IN_WAIT: begin
                mem_addr = dest_q;
                mem_data = in;
                if (in_valid) begin
                    mem_we  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                mem_we   = 1'b1;
                mem_addr = dest_q;
                state_d  = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        phase_d = (state_d != state_q) ? 2'd0 : (phase_q + 2'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FETCH;
            phase_q     <= 2'd0;
            pc_q        <= ADDR_WIDTH'(PC_START);
            ir_q        <= '0;
            b_q         <= '0;
            c_q         <= '0;
            ptr_q       <= '0;
            dest_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q     <= state_d;
            phase_q     <= phase_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            b_q         <= b_d;
            c_q         <= c_d;
            ptr_q       <= ptr_d;
            dest_q      <= dest_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign pc        = pc_q;
    assign sp        = '1;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign in_ready  = (state_q == S_IN_WAIT);
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_v2.sv
// Directed bench for cpu_v2: behavioural synchronous-read memory plus event recorders,
// with hand-computed expectations for each instruction class and timing boundary.
module tb_cpu_v2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mem_in;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [15:0] mem_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic [5:0]  pc;
    logic [5:0]  sp;
    logic        halted;

    int checks = 0;
    int errors = 0;

    cpu_v2 #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .PC_START(8)) dut (
        .clk(clk), .rst(rst), .mem_in(mem_in), .in(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .out(out_data), .out_valid(out_valid), .pc(pc), .sp(sp), .halted(halted)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [64];
    logic [15:0] mem_rd;
    logic        clr = 1'b0;
    logic        ld_en = 1'b0;
    logic [5:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;

    int          cyc, wr_cnt, ov_cnt, ir_cnt, ov_cyc;
    logic [5:0]  wr_addr_a [16];
    logic [15:0] wr_data_a [16];
    int          wr_cyc_a  [16];
    logic [5:0]  wr_pc_a   [16];

    assign mem_in = mem_rd;

    // Memory model and event recorders; cyc numbers the cycle ending at this edge.
    always @(posedge clk) begin
        mem_rd <= mem[mem_addr];
        if (clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
        if (rst) begin
            cyc <= 0; wr_cnt <= 0; ov_cnt <= 0; ir_cnt <= 0; ov_cyc <= 0;
        end else begin
            cyc <= cyc + 1;
            if (mem_we) begin
                wr_addr_a[wr_cnt[3:0]] <= mem_addr;
                wr_data_a[wr_cnt[3:0]] <= mem_data;
                wr_cyc_a[wr_cnt[3:0]]  <= cyc + 1;
                wr_pc_a[wr_cnt[3:0]]   <= pc;
                wr_cnt <= wr_cnt + 1;
            end
            if (out_valid) begin
                ov_cnt <= ov_cnt + 1;
                ov_cyc <= cyc + 1;
            end
            if (in_ready) ir_cnt <= ir_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [5:0] a, input logic [15:0] d);
        ld_addr = a; ld_data = d; ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic setup();
        @(negedge clk);
        rst = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Release on a falling edge: the following clock period is cycle 1 (first FETCH cycle).
    task automatic start();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_wr(input string tag, input int n, input int budget);
        int k = 0;
        while (wr_cnt < n && k < budget) begin @(negedge clk); k++; end
        check(tag, 32'(wr_cnt >= n), 32'd1);
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int k = 0;
        while (!halted && k < budget) begin @(negedge clk); k++; end
        check(tag, 32'(halted), 32'd1);
    endtask

    initial begin
        // Reset state
        setup();
        poke(6'd1, 16'd3); poke(6'd2, 16'd4);
        poke(6'd8, 16'h1012); poke(6'd9, 16'hF000);
        check("rst_pc", 32'(pc), 32'd8);
        check("rst_sp", 32'(sp), 32'h3F);
        check("rst_out", 32'(out_data), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_fetch_addr", 32'(mem_addr), 32'd8);

        // ADD direct: 3+4 -> mem[0] in cycle 8, pc already 9
        start();
        wait_wr("add_timeout", 1, 40);
        check("add_addr", 32'(wr_addr_a[0]), 32'd0);
        check("add_data", 32'(wr_data_a[0]), 32'd7);
        check("add_cycle", 32'(wr_cyc_a[0]), 32'd8);
        check("add_pc", 32'(wr_pc_a[0]), 32'd9);
        wait_halt("add_halt", 20);
        check("add_single_write", 32'(wr_cnt), 32'd1);

        // MOV immediate: two-word instruction, 6 cycles, pc +2
        setup();
        poke(6'd8, 16'h0008); poke(6'd9, 16'hBEEF); poke(6'd10, 16'hF000);
        start();
        wait_wr("movi_timeout", 1, 40);
        check("movi_addr", 32'(wr_addr_a[0]), 32'd0);
        check("movi_data", 32'(wr_data_a[0]), 32'hBEEF);
        check("movi_cycle", 32'(wr_cyc_a[0]), 32'd6);
        check("movi_pc", 32'(wr_pc_a[0]), 32'd10);

        // DIV by zero, MUL overflow, ordinary DIV
        setup();
        poke(6'd1, 16'd100); poke(6'd2, 16'd0); poke(6'd4, 16'h8000);
        poke(6'd5, 16'd2); poke(6'd6, 16'h1111); poke(6'd7, 16'd7);
        poke(6'd8, 16'h4312); poke(6'd9, 16'h3645); poke(6'd10, 16'h4017);
        poke(6'd11, 16'hF000);
        start();
        wait_wr("alu_timeout", 3, 80);
        check("div0_addr", 32'(wr_addr_a[0]), 32'd3);
        check("div0_data", 32'(wr_data_a[0]), 32'hFFFF);
        check("mul_addr", 32'(wr_addr_a[1]), 32'd6);
        check("mul_data", 32'(wr_data_a[1]), 32'd0);
        check("mul_cycle", 32'(wr_cyc_a[1]), 32'd16);
        check("div_data", 32'(wr_data_a[2]), 32'd14);
        check("div_cycle", 32'(wr_cyc_a[2]), 32'd24);

        // OUT with indirect A: out=mem[mem[1]]=5, strobe in cycle 8, no write
        setup();
        poke(6'd1, 16'd20); poke(6'd20, 16'd5);
        poke(6'd8, 16'h8900); poke(6'd9, 16'hF000);
        start();
        wait_halt("out_halt", 40);
        check("out_value", 32'(out_data), 32'd5);
        check("out_pulses", 32'(ov_cnt), 32'd1);
        check("out_cycle", 32'(ov_cyc), 32'd8);
        check("out_no_write", 32'(wr_cnt), 32'd0);

        // ADD with indirect A and C: mem[mem[3]] = mem[1] + mem[mem[2]], 12 cycles
        setup();
        poke(6'd1, 16'd3); poke(6'd2, 16'd30); poke(6'd30, 16'd4); poke(6'd3, 16'd40);
        poke(6'd8, 16'h1B1A); poke(6'd9, 16'hF000);
        start();
        wait_wr("ind_timeout", 1, 40);
        check("ind_addr", 32'(wr_addr_a[0]), 32'd40);
        check("ind_data", 32'(wr_data_a[0]), 32'd7);
        check("ind_cycle", 32'(wr_cyc_a[0]), 32'd12);

        // IN with delayed valid: ready in cycles 4..7, write in cycle 7
        setup();
        poke(6'd8, 16'h7500); poke(6'd9, 16'hF000);
        in_data = 16'h1234; in_valid = 1'b0;
        start();
        begin
            int k = 0;
            while (!in_ready && k < 20) begin @(negedge clk); k++; end
        end
        check("in_ready_seen", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("in_ready_held", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("in_ready_drop", 32'(in_ready), 32'd0);
        wait_halt("in_halt", 20);
        check("in_writes", 32'(wr_cnt), 32'd1);
        check("in_addr", 32'(wr_addr_a[0]), 32'd5);
        check("in_data", 32'(wr_data_a[0]), 32'h1234);
        check("in_cycle", 32'(wr_cyc_a[0]), 32'd7);
        check("in_ready_cycles", 32'(ir_cnt), 32'd4);

        // IN with valid already high: consumed on the first IN_WAIT cycle
        setup();
        poke(6'd8, 16'h7600); poke(6'd9, 16'hF000);
        in_data = 16'hABCD; in_valid = 1'b1;
        start();
        wait_wr("inpre_timeout", 1, 20);
        in_valid = 1'b0;
        check("inpre_data", 32'(wr_data_a[0]), 32'hABCD);
        check("inpre_cycle", 32'(wr_cyc_a[0]), 32'd4);

        // NOP then STOP: halted rises in cycle 7, pc frozen afterwards
        setup();
        poke(6'd8, 16'h5000); poke(6'd9, 16'hF000);
        start();
        repeat (5) @(negedge clk);
        check("stop_before", 32'(halted), 32'd0);
        @(negedge clk);
        check("stop_rise", 32'(halted), 32'd1);
        check("stop_pc", 32'(pc), 32'd10);
        repeat (20) @(negedge clk);
        check("halt_pc_frozen", 32'(pc), 32'd10);
        check("halt_no_write", 32'(wr_cnt), 32'd0);
        check("halt_we", 32'(mem_we), 32'd0);

        // Reset mid-ADD (cycle 6): no write, pc back to PC_START, then a clean rerun
        setup();
        poke(6'd1, 16'd3); poke(6'd2, 16'd4);
        poke(6'd8, 16'h1012); poke(6'd9, 16'hF000);
        start();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_we", 32'(mem_we), 32'd0);
        check("midrst_pc", 32'(pc), 32'd8);
        repeat (3) @(negedge clk);
        check("midrst_no_write", 32'(wr_cnt), 32'd0);
        start();
        wait_wr("rerun_timeout", 1, 40);
        check("rerun_data", 32'(wr_data_a[0]), 32'd7);
        check("rerun_cycle", 32'(wr_cyc_a[0]), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
